alu_seq: RTL

- Parametrised, registered successor to the combinational model-machine ALU.
- Keeps the legacy m/s opcode encoding and adds carry-chained arithmetic, OR/XOR, a signed-overflow flag and sign flag.
- Adds a valid/ready input handshake, a registered result and a persistent flag register.
- An optional iterative multiplier takes WIDTH cycles. The block sits between the register file/bus and the flag-driven branch logic of the CPU datapath.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_mul_iter.sv | 54 +++++
 rtl/alu_seq.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the registered sequential ALU.
package alu_pkg;

    // m=1 ALU functions (legacy select encoding)
    localparam logic [3:0] OP_ADD  = 4'b1001;
    localparam logic [3:0] OP_ADC  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SBB  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1011;
    localparam logic [3:0] OP_OR   = 4'b1110;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0101;
    localparam logic [3:0] OP_MUL  = 4'b1000;

    // m=0 transfer functions
    localparam logic [3:0] XFER_B  = 4'b1010;
    localparam logic [3:0] XFER_A0 = 4'b1100;
    localparam logic [3:0] XFER_A1 = 4'b0100;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle for WIDTH cycles.
// Instantiated by alu_seq only when ALU_SEQ_MUL_EN is defined.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] addend;

    // product is the accumulator after the current step, so the final value is
    // visible during the last step and stays put once mplier has drained to 0.
    assign addend  = mplier[0] ? mcand : '0;
    assign product = acc + addend;
    assign done    = busy && (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
            busy   <= 1'b0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= '0;
            busy   <= 1'b1;
        end else if (busy) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input handshake and persistent cf/zf/sf/vf flags.
// Define ALU_SEQ_MUL_EN to build the iterative multiplier (m=1, s=1000) and its MUL state.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter bit ZF_ON_LOGIC = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             m,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] t,
    output logic             out_valid,
    output logic             cf,
    output logic             zf,
    output logic             sf,
    output logic             vf
);

    localparam int MSB = WIDTH - 1;

    logic             accept;
    logic             is_mul;
    logic [WIDTH:0]   ext;
    logic [WIDTH-1:0] res;
    logic             arith;
    logic             add_op;
    logic             logic_op;
    logic             cf_n;
    logic             zf_n;
    logic             sf_n;
    logic             vf_n;

    assign accept = in_valid && in_ready;

`ifdef ALU_SEQ_MUL_EN
    state_t             state;
    state_t             state_n;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign is_mul    = m && (s == OP_MUL);
    assign mul_start = accept && is_mul;
    assign in_ready  = (state == ST_IDLE);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: if (mul_start) state_n = ST_MUL;
            // Leaving on !mul_busy as well keeps the FSM from sticking if the
            // multiplier ever drops out early.
            ST_MUL:  if (mul_done || !mul_busy) state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end
`else
    assign is_mul   = 1'b0;
    assign in_ready = 1'b1;
`endif

    // NOTE: every output of this always_comb gets a default before the case
    // statements; a path that skips an assignment would otherwise infer a latch.
    always_comb begin
        ext      = '0;
        res      = '0;
        arith    = 1'b0;
        add_op   = 1'b0;
        logic_op = 1'b0;
        cf_n     = 1'b0;
        zf_n     = 1'b0;
        sf_n     = 1'b0;
        vf_n     = 1'b0;

        if (m) begin
            case (s)
                OP_ADD: begin
                    ext = {1'b0, a} + {1'b0, b};
                    arith = 1'b1; add_op = 1'b1;
                end
                OP_ADC: begin
                    ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cf};
                    arith = 1'b1; add_op = 1'b1;
                end
                OP_SUB: begin
                    ext = {1'b0, b} - {1'b0, a};
                    arith = 1'b1;
                end
                OP_SBB: begin
                    ext = {1'b0, b} - {1'b0, a} - {{WIDTH{1'b0}}, cf};
                    arith = 1'b1;
                end
                OP_AND:  begin res = a & b; logic_op = 1'b1; end
                OP_OR:   begin res = a | b; logic_op = 1'b1; end
                OP_XOR:  begin res = a ^ b; logic_op = 1'b1; end
                OP_NOT:  begin res = ~b;    logic_op = 1'b1; end
                default: ;
            endcase
        end else begin
            case (s)
                XFER_B:           begin res = b; logic_op = 1'b1; end
                XFER_A0, XFER_A1: begin res = a; logic_op = 1'b1; end
                default: ;
            endcase
        end

        if (arith) begin
            res  = ext[WIDTH-1:0];
            cf_n = ext[WIDTH];
            zf_n = (res == '0);
            sf_n = res[MSB];
            // Subtraction is b - a, so overflow is judged against b's sign.
            vf_n = add_op ? ((a[MSB] == b[MSB]) && (res[MSB] != a[MSB]))
                          : ((a[MSB] != b[MSB]) && (res[MSB] != b[MSB]));
        end else if (logic_op && ZF_ON_LOGIC) begin
            zf_n = (res == '0);
            sf_n = res[MSB];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, e.g. ADC reading cf before this op overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t         <= '0;
            cf        <= 1'b0;
            zf        <= 1'b0;
            sf        <= 1'b0;
            vf        <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (accept && !is_mul) begin
                t         <= res;
                cf        <= cf_n;
                zf        <= zf_n;
                sf        <= sf_n;
                vf        <= vf_n;
                out_valid <= 1'b1;
            end
`ifdef ALU_SEQ_MUL_EN
            else if (mul_done) begin
                t         <= mul_product[WIDTH-1:0];
                cf        <= |mul_product[2*WIDTH-1:WIDTH];
                zf        <= (mul_product[WIDTH-1:0] == '0);
                sf        <= mul_product[MSB];
                vf        <= 1'b0;
                out_valid <= 1'b1;
            end
`endif
        end
    end

endmodule
